// File: rtl/cs_product_resolver.sv
// Sequential carry-propagate resolver: adds a carry-save (sum, carry) pair CHUNK bits per cycle.
// Optional registered all-zero flag on the result when CS_RESOLVE_ZERO_EN is defined.
module cs_product_resolver #(
  parameter int N     = 17,
  parameter int M     = 17,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N+M-1:0]   in_sum,
  input  logic [N+M-1:0]   in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N+M-1:0]   out_prod,
  output logic             busy
`ifdef CS_RESOLVE_ZERO_EN
  ,
  output logic             out_zero
`endif
);

  localparam int W      = N + M;
  localparam int NCHUNK = (W + CHUNK - 1) / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          state, state_next;
  logic [W-1:0]    op_sum, op_carry;
  logic [CW-1:0]   cnt;
  logic            cry;
  logic            accept, last_slice;
  logic [31:0]     shift_amt;
  logic [CHUNK-1:0] a_slice, b_slice;
  logic [CHUNK:0]  slice_sum;
  logic [W-1:0]    slice_w, mask_w, prod_next;
`ifdef CS_RESOLVE_ZERO_EN
  logic            slice_zero;
`endif

  // Datapath for the slice currently addressed by cnt; a narrower final
  // slice falls out naturally because bits shifted past W read as zero.
  always_comb begin
    shift_amt = 32'(cnt) * 32'(CHUNK);
    a_slice   = CHUNK'(op_sum >> shift_amt);
    b_slice   = CHUNK'(op_carry >> shift_amt);
    slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, cry};
    slice_w   = W'(slice_sum) << shift_amt;
    mask_w    = W'({CHUNK{1'b1}}) << shift_amt;
    prod_next = (out_prod & ~mask_w) | (slice_w & mask_w);
`ifdef CS_RESOLVE_ZERO_EN
    slice_zero = ((slice_w & mask_w) == '0);
`endif
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    last_slice = (cnt == LAST);
    case (state)
      IDLE: in_ready = 1'b1;
      ADD: begin
        busy = 1'b1;
        if (last_slice) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_next = in_valid ? ADD : IDLE;
      end
      default: state_next = IDLE;
    endcase
    accept = in_valid && in_ready;
    if (accept) state_next = ADD;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_sum   <= '0;
      op_carry <= '0;
      cnt      <= '0;
      cry      <= 1'b0;
      out_prod <= '0;
`ifdef CS_RESOLVE_ZERO_EN
      out_zero <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (accept) begin
        op_sum   <= in_sum;
        op_carry <= in_carry;
        cnt      <= '0;
        cry      <= 1'b0;
`ifdef CS_RESOLVE_ZERO_EN
        out_zero <= 1'b1;
`endif
      end else if (state == ADD) begin
        out_prod <= prod_next;
        // Carry out of the top slice is bit W and is dropped.
        cry      <= last_slice ? 1'b0 : slice_sum[CHUNK];
        cnt      <= last_slice ? '0 : cnt + 1'b1;
`ifdef CS_RESOLVE_ZERO_EN
        out_zero <= out_zero & slice_zero;
`endif
      end
    end
  end

endmodule

// File: doc/cs_product_resolver.md
# cs_product_resolver

Sequential carry-propagate resolver for the redundant carry-save product pair (sum and carry vectors, sign-correction constant already folded in) produced by the Wallace/Dadda multiplier wrappers. It accepts one carry-save pair per transaction, adds the two vectors CHUNK bits per cycle, and returns the final two's-complement product modulo 2^(N+M). It sits directly downstream of the multiplier and trades latency for a short adder critical path.

## Interface
- N, 17, multiplicand width
- M, 17, multiplier width
- CHUNK, 8, bits resolved per cycle (1 ≤ CHUNK ≤ N+M)
- Derived: W = N+M; NCHUNK = ceil(W/CHUNK)

- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  carry-save pair present
- in_ready  out  1  resolver can accept a pair
- in_sum  in  W  carry-save sum vector
- in_carry  in  W  carry-save carry vector (already bit-aligned; no internal shift)
- out_valid  out  1  out_prod holds a result
- out_ready  in  1  consumer takes the result
- out_prod  out  W  in_sum + in_carry mod 2^W
- busy  out  1  high in ADD state
- out_zero  out  1  present only with CS_RESOLVE_ZERO_EN (see Configuration)

## Operation
- States: IDLE, ADD, DONE. Reset → IDLE.
- Reset values: in_ready=1 (combinational, from IDLE), out_valid=0, busy=0, out_prod=0, chunk counter=0, carry register=0, out_zero=0.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_sum/in_carry into operand registers, clear the carry register and counter, go to ADD.
- ADD: each cycle, add slice k of both operands plus the carry register; write the CHUNK-bit sum into out_prod slice k and the carry-out into the carry register; k++. The final slice may be narrower than CHUNK (W mod CHUNK bits); its carry-out (bit W) is discarded. After slice NCHUNK-1, go to DONE.
- out_prod slices not yet written in the current transaction hold stale data; out_prod is only meaningful while out_valid=1.
- DONE: out_valid=1; out_prod stable. in_ready = out_ready.
  - out_ready=0: stay in DONE; hold everything.
  - out_ready=1, in_valid=0: → IDLE.
  - out_ready=1, in_valid=1: result consumed and new pair accepted on the same edge → ADD (back-to-back, no idle bubble).
- in_ready=0 in ADD; in_valid is ignored there.
- Inputs are sampled only on the accepting edge; later changes to in_sum/in_carry have no effect.
- rst mid-transaction: the transaction is abandoned, all state returns to reset values on that edge, and no out_valid pulse is produced for the abandoned pair.

## Timing
- Acceptance edge t. ADD occupies edges t+1 … t+NCHUNK. out_valid=1 in the cycle after edge t+NCHUNK, i.e. latency = NCHUNK cycles from acceptance to out_valid.
- Default parameters: W=34, NCHUNK=5, latency 5.
- Sustained throughput with out_ready held at 1 and in_valid held at 1: one result per NCHUNK+1 cycles.
- Longest combinational path: one CHUNK-bit adder plus carry-in. No combinational path exists from in_* to out_*; in_ready depends combinationally on out_ready only in DONE.

## Configuration
- CS_RESOLVE_ZERO_EN defined: out_zero port exists. It is registered, valid with out_valid, and equals 1 if and only if out_prod == 0. It is computed incrementally by ANDing a per-slice zero flag during ADD, cleared to 0 on reset, and re-initialised on each acceptance.
- Not defined: the port, logic, and per-slice flag are all absent. Behaviour is otherwise identical.

## Test plan
- Basic: in_sum=34'h0000_0000F, in_carry=0 → out_valid exactly 5 cycles after acceptance, out_prod=34'h0_0000_000F, out_zero=0.
- Cross-chunk carry ripple: in_sum=34'h0_0000_00FF, in_carry=34'h1 → out_prod=34'h0_0000_0100; in_sum=34'h3_FFFF_FFFF, in_carry=34'h1 → out_prod=0 (carry out of bit 33 dropped), out_zero=1.
- Signed product end-to-end: drive the multiplier wrapper output pair for a=-3 and b=5 (17-bit two's complement) → out_prod=34'h3_FFFF_FFF1. Sweep 1000 random a/b pairs and compare against the signed a*b truncated to W bits, with CHUNK set to each of 1, 8, 13, and 34.
- Backpressure and back-to-back: hold out_ready=0 for 7 cycles in DONE → out_prod stable and in_ready=0 throughout; then raise out_ready with in_valid=1 → result consumed and new pair accepted on the same edge, next out_valid 5 cycles later.
- Reset mid-operation: assert rst for 1 cycle during ADD slice 2 → next cycle in_ready=1, out_valid=0, busy=0; the following transaction returns a correct result with no residual carry.
- Input stability: change in_sum/in_carry every cycle during ADD → result matches the values sampled on the acceptance edge.
